fft_bfly_scheduler: RTL and testbench
=====================================

# fft_bfly_scheduler

Sequencing controller for the radix-2 DIT FFT datapath. After a start command it walks every stage and butterfly of an N-point transform, N ∈ {2, 4, 8, 16, 32} chosen at run time. Each butterfly is issued as a pair of in-place memory addresses plus the twiddle index `k` and size `n` for the unified twiddle ROM, over a valid/ready handshake. Between stages it inserts a pipeline drain so that stage s+1 never reads data that stage s has not yet written back.

## Interface
Parameters:
- `MAX_N`, 32, largest supported transform; power of two, ≤ 32.
- `ADDR_WIDTH`, `$clog2(MAX_N)`, width of the data-memory address and of the twiddle index.
- `PIPE_DEPTH`, 3, drain cycles inserted after the last butterfly of each stage; 0 is legal.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `n_points` in ADDR_WIDTH+1: transform size; captured on the accepted `start`.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle pulse at completion.
- `cfg_err` out 1: one-cycle pulse when `start` arrives with an illegal `n_points`.
- `bfly_valid` out 1: butterfly descriptor is valid.
- `bfly_ready` in 1: datapath accepts the descriptor.
- `addr_a` out ADDR_WIDTH: top-leg address.
- `addr_b` out ADDR_WIDTH: bottom-leg address, equal to `addr_a` + 2^stage.
- `tw_k` out ADDR_WIDTH: twiddle index to the ROM, always < N/2.
- `tw_n` out ADDR_WIDTH+1: latched N, passed to the ROM.
- `stage` out 3: current stage, 0..log2N−1.
- `last_bfly` out 1: descriptor is the final butterfly of the final stage.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start` with a legal N.
  - Latch N, compute L = log2N, clear `stage` and the butterfly counter `i`.
- IDLE → IDLE on `start` with an illegal N (not a power of two in 2..MAX_N): pulse `cfg_err` and latch nothing.
- Descriptor for stage s and counter i (i = 0..N/2−1), with h = 2^s and j = i mod h:
  - `addr_a` = ((i >> s) << (s+1)) | j
  - `addr_b` = `addr_a` + h
  - `tw_k` = j << (L−1−s)
- In RUN, `i` advances only on the handshake `bfly_valid && bfly_ready`.
- On the handshake of i = N/2−1:
  - go to DRAIN if `PIPE_DEPTH` > 0;
  - otherwise go straight to the next stage, or to DONE after the last stage.
- DRAIN counts `PIPE_DEPTH` cycles with `bfly_valid` = 0, then:
  - if `stage` < L−1: increment `stage`, clear `i`, return to RUN;
  - otherwise go to DONE.
- DONE lasts one cycle with `done` = 1, then returns to IDLE.
- `start` outside IDLE is ignored, and `n_points` changes while busy have no effect.
- All address and index arithmetic is unsigned and ADDR_WIDTH bits wide; no wrap-around can occur for a legal N.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`, `done`, `cfg_err`, `bfly_valid`, `last_bfly` = 0
  - `addr_a`, `addr_b`, `tw_k`, `stage` = 0
  - `tw_n` = 0
- `rst` in any state returns to IDLE at the next edge and aborts the transform; no `done` is produced.
- `start` accepted at edge t: `busy` = 1 and `bfly_valid` = 1, carrying butterfly (0, 2^0 = 1, 0), from cycle t+1.
- Stall: while `bfly_ready` = 0, every descriptor output holds stable.
- Throughput with no stalls: one butterfly per cycle.
- Total latency from the accepted `start` to the `done` cycle: L·(N/2 + PIPE_DEPTH) + 1 cycles.
- `busy` = 1 in RUN and DRAIN; it is 0 in the DONE cycle.
- A new `start` is accepted no earlier than the cycle after `done`.

## Structure
- Shared FFT package holds:
  - the state enumeration;
  - the legal-N check and the log2N function (N → L);
  - `MAX_N`-derived widths shared with the twiddle ROM.
- Natural sub-module: `fft_bfly_addr_gen`, the combinational map (s, i, L) → (`addr_a`, `addr_b`, `tw_k`). It is reused later by the in-place memory bank selector.
- The FSM, stage/butterfly counters and drain counter stay in this block.

## Test plan
- N=8, `PIPE_DEPTH`=2, `bfly_ready` tied to 1, `start` at cycle 0. Required descriptors (`addr_a`, `addr_b`, `tw_k`):
  - stage 0 = (0,1,0) (2,3,0) (4,5,0) (6,7,0), in cycles 1–4;
  - stage 1 = (0,2,0) (1,3,2) (4,6,0) (5,7,2), in cycles 7–10;
  - stage 2 = (0,4,0) (1,5,1) (2,6,2) (3,7,3), in cycles 13–16, with `last_bfly` = 1 in cycle 16;
  - `done` in cycle 19.
- N=32, `PIPE_DEPTH`=0:
  - 80 butterflies back-to-back;
  - every `tw_k` < 16 and `tw_n` = 32 throughout;
  - `done` 81 cycles after `start`.
- Randomised `bfly_ready` stalls on N=16:
  - descriptors hold stable while stalled;
  - sequence identical to the unstalled run.
- `start` with `n_points` = 12, then 0, then 64:
  - `cfg_err` pulses once each;
  - `busy` stays 0.
- N=16 aborted:
  - `rst` asserted in stage 2 mid-RUN, and separately mid-DRAIN;
  - next cycle all outputs at reset values and no `done`;
  - a fresh N=4 transform then completes correctly.
- N=2:
  - single butterfly (0,1,0) with `last_bfly` = 1;
  - `start` re-asserted while busy is ignored.

Source files
------------

// File: rtl/fft_bfly_scheduler_pkg.sv
// rtl/fft_bfly_scheduler_pkg.sv - shared FFT scheduler state encoding, widths and size helpers
package fft_bfly_scheduler_pkg;

   localparam int FFT_MAX_N   = 32;
   localparam int FFT_ADDR_W  = $clog2(FFT_MAX_N);
   localparam int FFT_STAGE_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fft_state_e;

   // Legal sizes are powers of two from 2 up to the configured maximum.
   function automatic logic fft_n_legal(input int unsigned n, input int unsigned max_n);
      return (n >= 32'd2) && (n <= max_n) && ((n & (n - 32'd1)) == 32'd0);
   endfunction

   function automatic logic [FFT_STAGE_W-1:0] fft_log2(input int unsigned n);
      logic [FFT_STAGE_W-1:0] l;
      l = '0;
      for (int b = 1; b < 6; b++) begin
         if (n == (32'd1 << b)) l = FFT_STAGE_W'(b);
      end
      return l;
   endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// rtl/fft_bfly_addr_gen.sv - maps (stage, butterfly index, log2N) to in-place addresses and twiddle index
module fft_bfly_addr_gen
   import fft_bfly_scheduler_pkg::*;
#(
   parameter int ADDR_WIDTH = FFT_ADDR_W
) (
   input  logic [FFT_STAGE_W-1:0] stage_i,
   input  logic [ADDR_WIDTH-1:0]  bfly_i,
   input  logic [FFT_STAGE_W-1:0] log2n_i,
   output logic [ADDR_WIDTH-1:0]  addr_a_o,
   output logic [ADDR_WIDTH-1:0]  addr_b_o,
   output logic [ADDR_WIDTH-1:0]  tw_k_o
);

   logic [ADDR_WIDTH-1:0] span;
   logic [ADDR_WIDTH-1:0] j;

   assign span = ADDR_WIDTH'(1) << stage_i;
   assign j    = bfly_i & (span - ADDR_WIDTH'(1));

   // Group index is spread over pairs of 2*span; j selects the position inside a group.
   assign addr_a_o = ((bfly_i >> stage_i) << (stage_i + FFT_STAGE_W'(1))) | j;
   assign addr_b_o = addr_a_o + span;
   assign tw_k_o   = j << (log2n_i - stage_i - FFT_STAGE_W'(1));

endmodule

// File: rtl/fft_bfly_scheduler.sv
// rtl/fft_bfly_scheduler.sv - radix-2 DIT FFT butterfly sequencer with inter-stage pipeline drain
module fft_bfly_scheduler
   import fft_bfly_scheduler_pkg::*;
#(
   parameter int MAX_N      = FFT_MAX_N,
   parameter int ADDR_WIDTH = $clog2(MAX_N),
   parameter int PIPE_DEPTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH:0]    n_points,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output logic                   bfly_valid,
   input  logic                   bfly_ready,
   output logic [ADDR_WIDTH-1:0]  addr_a,
   output logic [ADDR_WIDTH-1:0]  addr_b,
   output logic [ADDR_WIDTH-1:0]  tw_k,
   output logic [ADDR_WIDTH:0]    tw_n,
   output logic [FFT_STAGE_W-1:0] stage,
   output logic                   last_bfly
);

   localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

   fft_state_e             state_q, state_d;
   logic [FFT_STAGE_W-1:0] stage_q, stage_d;
   logic [FFT_STAGE_W-1:0] l_q, l_d;
   logic [ADDR_WIDTH-1:0]  i_q, i_d;
   logic [ADDR_WIDTH-1:0]  last_i_q, last_i_d;
   logic [ADDR_WIDTH:0]    n_q, n_d;
   logic [DW-1:0]          drain_q, drain_d;

   logic busy_q, busy_d;
   logic done_q, done_d;
   logic cfg_err_q, cfg_err_d;
   logic valid_q, valid_d;
   logic last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q, tw_k_q;
   logic [ADDR_WIDTH-1:0] gen_a, gen_b, gen_k;

   logic n_ok;
   logic stage_end;
   logic final_stage;
   logic adv;

   assign n_ok        = fft_n_legal(32'(n_points), 32'(MAX_N));
   assign stage_end   = (i_q == last_i_q);
   assign final_stage = (stage_q == (l_q - FFT_STAGE_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         stage_q  <= '0;
         l_q      <= '0;
         i_q      <= '0;
         last_i_q <= '0;
         n_q      <= '0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         l_q      <= l_d;
         i_q      <= i_d;
         last_i_q <= last_i_d;
         n_q      <= n_d;
         drain_q  <= drain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      l_d      = l_q;
      i_d      = i_q;
      last_i_d = last_i_q;
      n_d      = n_q;
      drain_d  = drain_q;
      adv      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && n_ok) begin
               state_d  = ST_RUN;
               n_d      = n_points;
               l_d      = fft_log2(32'(n_points));
               last_i_d = ADDR_WIDTH'(n_points >> 1) - ADDR_WIDTH'(1);
               stage_d  = '0;
               i_d      = '0;
            end
         end
         ST_RUN: begin
            if (bfly_ready) begin
               if (!stage_end) begin
                  i_d = i_q + ADDR_WIDTH'(1);
               end else if (PIPE_DEPTH > 0) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) adv = 1'b1;
            else                       drain_d = drain_q + DW'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A finished stage either opens the next one or ends the transform.
      if (adv) begin
         if (final_stage) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_RUN;
            stage_d = stage_q + FFT_STAGE_W'(1);
            i_d     = '0;
         end
      end
   end

   fft_bfly_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .stage_i (stage_d),
      .bfly_i  (i_d),
      .log2n_i (l_d),
      .addr_a_o(gen_a),
      .addr_b_o(gen_b),
      .tw_k_o  (gen_k)
   );

   // Outputs are computed from the next state so the registers line up with stage_q.
   always_comb begin
      busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d    = (state_d == ST_DONE);
      valid_d   = (state_d == ST_RUN);
      last_d    = valid_d && (stage_d == (l_d - FFT_STAGE_W'(1))) && (i_d == last_i_d);
      cfg_err_d = (state_q == ST_IDLE) && start && !n_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         tw_k_q    <= '0;
      end else begin
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         addr_a_q  <= gen_a;
         addr_b_q  <= gen_b;
         tw_k_q    <= gen_k;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign bfly_valid = valid_q;
   assign last_bfly  = last_q;
   assign addr_a     = addr_a_q;
   assign addr_b     = addr_b_q;
   assign tw_k       = tw_k_q;
   assign tw_n       = n_q;
   assign stage      = stage_q;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// tb/tb_fft_bfly_scheduler.sv - scoreboard bench for fft_bfly_scheduler (drain 2 and drain 0 instances)
module tb_fft_bfly_scheduler;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    start = 2'b00;
   logic [AW:0]   n_points = '0;
   logic          bfly_ready = 1'b1;
   logic [1:0]    busy, done, cfg_err, bfly_valid, last_bfly;
   logic [AW-1:0] addr_a [2];
   logic [AW-1:0] addr_b [2];
   logic [AW-1:0] tw_k [2];
   logic [AW:0]   tw_n [2];
   logic [2:0]    stage [2];

   always #5 clk = ~clk;

   fft_bfly_scheduler #(.MAX_N(32), .ADDR_WIDTH(AW), .PIPE_DEPTH(2)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .n_points(n_points),
      .busy(busy[0]), .done(done[0]), .cfg_err(cfg_err[0]),
      .bfly_valid(bfly_valid[0]), .bfly_ready(bfly_ready),
      .addr_a(addr_a[0]), .addr_b(addr_b[0]), .tw_k(tw_k[0]), .tw_n(tw_n[0]),
      .stage(stage[0]), .last_bfly(last_bfly[0])
   );

   fft_bfly_scheduler #(.MAX_N(32), .ADDR_WIDTH(AW), .PIPE_DEPTH(0)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .n_points(n_points),
      .busy(busy[1]), .done(done[1]), .cfg_err(cfg_err[1]),
      .bfly_valid(bfly_valid[1]), .bfly_ready(bfly_ready),
      .addr_a(addr_a[1]), .addr_b(addr_b[1]), .tw_k(tw_k[1]), .tw_n(tw_n[1]),
      .stage(stage[1]), .last_bfly(last_bfly[1])
   );

   typedef struct {
      int a;
      int b;
      int k;
      int s;
      int last;
      int cyc;
   } desc_t;

   desc_t exp_arr [2][256];
   int wr_p [2], rd_p [2], active [2], start_cyc [2], stall_cnt [2];
   int exp_lat [2], exp_n [2], cfg_seen [2], cfg_exp [2];
   int stalled [2], held_a [2], held_b [2], held_k [2], held_last [2];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pd(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic int log2i(input int n);
      int l = 0;
      while ((1 << l) < n) l++;
      return l;
   endfunction

   function automatic bit legal(input int n);
      return (n >= 2) && (n <= 32) && ((n & (n - 1)) == 0);
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[dut%0d]: got %0d, expected %0d at cycle %0d", nm, k, act, exp, cyc);
      end
   endtask

   // Reference: every stage pairs elements h apart inside blocks of 2h; twiddle step is N/(2h).
   task automatic push_model(input int k, input int n);
      int L, h, a, idx, p;
      L = log2i(n);
      p = pd(k);
      idx = 0;
      for (int s = 0; s < L; s++) begin
         h = 1 << s;
         for (int i = 0; i < n / 2; i++) begin
            a = (i / h) * 2 * h + (i % h);
            exp_arr[k][idx].a    = a;
            exp_arr[k][idx].b    = a + h;
            exp_arr[k][idx].k    = (i % h) * (n / (2 * h));
            exp_arr[k][idx].s    = s;
            exp_arr[k][idx].last = int'((s == L - 1) && (i == n / 2 - 1));
            exp_arr[k][idx].cyc  = 1 + s * (n / 2 + p) + i;
            idx++;
         end
      end
      rd_p[k]    = 0;
      wr_p[k]    = idx;
      exp_lat[k] = L * (n / 2 + p) + 1;
      exp_n[k]   = n;
   endtask

   initial begin
      desc_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               stalled[k] = 0;
            end else begin
               if (stalled[k] != 0) begin
                  chk("stall_valid", k, int'(bfly_valid[k]), 1);
                  chk("stall_addr_a", k, int'(addr_a[k]), held_a[k]);
                  chk("stall_addr_b", k, int'(addr_b[k]), held_b[k]);
                  chk("stall_tw_k", k, int'(tw_k[k]), held_k[k]);
                  chk("stall_last", k, int'(last_bfly[k]), held_last[k]);
               end
               stalled[k] = 0;
               if (cfg_err[k]) cfg_seen[k]++;
               chk("busy", k, int'(busy[k]), int'((active[k] != 0) && !done[k]));
               if (bfly_valid[k]) begin
                  if (!bfly_ready) begin
                     stall_cnt[k]++;
                     stalled[k]   = 1;
                     held_a[k]    = int'(addr_a[k]);
                     held_b[k]    = int'(addr_b[k]);
                     held_k[k]    = int'(tw_k[k]);
                     held_last[k] = int'(last_bfly[k]);
                  end else begin
                     chk("desc_pending", k, int'(rd_p[k] < wr_p[k]), 1);
                     if (rd_p[k] < wr_p[k]) begin
                        e = exp_arr[k][rd_p[k]];
                        rd_p[k]++;
                        chk("addr_a", k, int'(addr_a[k]), e.a);
                        chk("addr_b", k, int'(addr_b[k]), e.b);
                        chk("tw_k", k, int'(tw_k[k]), e.k);
                        chk("stage", k, int'(stage[k]), e.s);
                        chk("last_bfly", k, int'(last_bfly[k]), e.last);
                        chk("tw_n", k, int'(tw_n[k]), exp_n[k]);
                        if (stall_cnt[k] == 0)
                           chk("desc_cycle", k, cyc - start_cyc[k], e.cyc);
                     end
                  end
               end
               if (done[k]) begin
                  chk("done_expected", k, active[k], 1);
                  if (active[k] != 0) begin
                     chk("done_latency", k, cyc - start_cyc[k], exp_lat[k] + stall_cnt[k]);
                     chk("all_issued", k, rd_p[k], wr_p[k]);
                  end
                  active[k] = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         bfly_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic wait_idle(input int k);
      int t = 0;
      while ((active[k] != 0) && (t < 5000)) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("idle_timeout", k, int'(t < 5000), 1);
   endtask

   task automatic do_start(input int k, input int n);
      wait_idle(k);
      n_points = n[AW:0];
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      if (legal(n)) begin
         push_model(k, n);
         start_cyc[k] = cyc - 1;
         stall_cnt[k] = 0;
         active[k]    = 1;
      end else begin
         cfg_exp[k]++;
         chk("cfg_err_pulse", k, int'(cfg_err[k]), 1);
         chk("cfg_busy", k, int'(busy[k]), 0);
      end
   endtask

   task automatic check_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, int'(busy[k]), 0);
         chk("rst_done", k, int'(done[k]), 0);
         chk("rst_cfg_err", k, int'(cfg_err[k]), 0);
         chk("rst_valid", k, int'(bfly_valid[k]), 0);
         chk("rst_last", k, int'(last_bfly[k]), 0);
         chk("rst_addr_a", k, int'(addr_a[k]), 0);
         chk("rst_addr_b", k, int'(addr_b[k]), 0);
         chk("rst_tw_k", k, int'(tw_k[k]), 0);
         chk("rst_stage", k, int'(stage[k]), 0);
         chk("rst_tw_n", k, int'(tw_n[k]), 0);
      end
   endtask

   task automatic abort_when(input bit in_drain);
      int t = 0;
      do_start(0, 16);
      while (t < 500 && !(busy[0] && stage[0] == 3'd2 && (in_drain ? !bfly_valid[0] : bfly_valid[0]))) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(in_drain ? "abort_drain_reach" : "abort_run_reach", 0, int'(t < 500), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      active[0] = 0;
      wr_p[0]   = 0;
      rd_p[0]   = 0;
      check_reset();
      repeat (6) @(posedge clk);
      #1;
   endtask

   int illegal_n [4] = '{12, 0, 64, 3};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset();

      do_start(0, 8);
      wait_idle(0);

      do_start(1, 32);
      do_start(0, 32);
      wait_idle(0);
      wait_idle(1);

      rand_rdy = 1'b1;
      do_start(0, 16);
      do_start(1, 16);
      for (int r = 0; r < 6; r++) begin
         do_start(int'($urandom_range(0, 1)), 2 << $urandom_range(0, 4));
      end
      wait_idle(0);
      wait_idle(1);
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;

      foreach (illegal_n[x]) do_start(0, illegal_n[x]);
      do_start(1, 24);

      abort_when(1'b0);
      abort_when(1'b1);
      do_start(0, 4);
      wait_idle(0);

      do_start(0, 2);
      start[0] = 1'b1;
      n_points = 6'd8;
      repeat (2) @(posedge clk);
      #1;
      start[0] = 1'b0;
      wait_idle(0);

      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("cfg_err_count", k, cfg_seen[k], cfg_exp[k]);
         chk("queue_drained", k, rd_p[k], wr_p[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
